// File: rtl/fixed_point_mac.sv
// fixed_point_mac: streaming sign-magnitude fixed-point multiply-accumulate.
// Each vector is a burst of (a,b) beats ended by in_last_i; the result is the
// saturated dot product in the same SIGN+Q_M+Q_N sign-magnitude format.
//
// Ports
//   clk_i, rst_ni            clock / asynchronous active-low reset
//   in_valid_i, in_ready_o   operand beat handshake
//   in_last_i                beat is the final term of the vector
//   a_in, b_in               operands, sign-magnitude (sign at MSB if SIGN=1)
//   out_valid_o, out_ready_i result handshake
//   y_out                    saturated dot product, sign-magnitude
//   overflow_o               saturation or accumulator clamp seen in this vector
module fixed_point_mac #(
  parameter int SIGN      = 1,
  parameter int Q_M       = 16,
  parameter int Q_N       = 16,
  parameter int ACC_GUARD = 8,
  parameter int ROUND     = 0
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic                      in_last_i,
  input  logic [SIGN+Q_M+Q_N-1:0]   a_in,
  input  logic [SIGN+Q_M+Q_N-1:0]   b_in,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [SIGN+Q_M+Q_N-1:0]   y_out,
  output logic                      overflow_o
);
  localparam int W    = SIGN + Q_M + Q_N;
  localparam int MAG  = Q_M + Q_N;
  localparam int PW   = 2 * MAG;                 // full product width
  localparam int TW   = PW + 1;                  // signed term width
  localparam int ACCW = MAG + ACC_GUARD + 1;     // accumulator width
  localparam int SW   = ((TW > ACCW) ? TW : ACCW) + 1;  // exact sum width

  localparam logic signed [ACCW-1:0] ACC_MAX = {1'b0, {(ACCW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] ACC_MIN = {1'b1, {(ACCW-1){1'b0}}};
  localparam logic        [MAG-1:0]  MAG_MAX = '1;

  // ---------------- stage 1: multiply, round, shift, apply sign ----------------
  logic                 w_accept;
  logic                 w_sa, w_sb;
  logic [PW-1:0]        w_prod, w_rnd, w_pmag;
  logic signed [TW-1:0] w_term;

  assign w_accept = in_valid_i & in_ready_o;
  assign w_sa     = (SIGN != 0) ? a_in[W-1] : 1'b0;
  assign w_sb     = (SIGN != 0) ? b_in[W-1] : 1'b0;
  assign w_prod   = PW'(a_in[MAG-1:0]) * PW'(b_in[MAG-1:0]);
  assign w_rnd    = (ROUND != 0) ? (PW'(1) << (Q_N - 1)) : '0;
  // (2^MAG-1)^2 + 2^(Q_N-1) still fits in PW bits, so the rounding add cannot wrap.
  assign w_pmag   = (w_prod + w_rnd) >> Q_N;
  // Negating a zero magnitude yields zero, so no negative zero reaches the sum.
  assign w_term   = (w_sa ^ w_sb) ? -$signed({1'b0, w_pmag}) : $signed({1'b0, w_pmag});

  logic                 r_s1_vld, r_s1_last;
  logic signed [TW-1:0] r_s1_term;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s1_vld  <= 1'b0;
      r_s1_last <= 1'b0;
      r_s1_term <= '0;
    end else begin
      r_s1_vld <= w_accept;
      if (w_accept) begin
        r_s1_last <= in_last_i;
        r_s1_term <= w_term;
      end
    end
  end

  // ---------------- stage 2: accumulate / convert ----------------
  logic signed [ACCW-1:0] r_acc;
  logic                   r_sticky;
  logic signed [SW-1:0]   w_sum;
  logic                   w_hi, w_lo;
  logic signed [ACCW-1:0] w_acc_nxt;
  logic                   w_neg, w_sat;
  logic [SW-1:0]          w_abs;
  logic [W-1:0]           w_y;
  logic                   w_ovf;

  // Sum is formed wide enough to be exact; clamping and saturation act on it.
  assign w_sum = SW'(r_acc) + SW'(r_s1_term);
  assign w_hi  = w_sum > SW'(ACC_MAX);
  assign w_lo  = w_sum < SW'(ACC_MIN);
  assign w_acc_nxt = w_hi ? ACC_MAX : (w_lo ? ACC_MIN : w_sum[ACCW-1:0]);

  assign w_neg = w_sum[SW-1];
  assign w_abs = w_neg ? 0 - w_sum : w_sum;
  assign w_sat = w_abs > SW'(MAG_MAX);

  always_comb begin
    w_y   = '0;
    w_ovf = r_sticky;
    if (w_neg && (SIGN == 0)) begin
      // unsigned format cannot express a negative result: clamp to zero
      w_ovf = 1'b1;
    end else begin
      w_y[MAG-1:0] = w_sat ? MAG_MAX : w_abs[MAG-1:0];
      w_ovf        = w_ovf | w_sat;
      if (SIGN != 0) w_y[W-1] = w_neg;
    end
  end

  logic r_busy, r_out_valid, r_ovf;
  logic [W-1:0] r_y;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_acc       <= '0;
      r_sticky    <= 1'b0;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_y         <= '0;
      r_ovf       <= 1'b0;
    end else begin
      if (r_out_valid && out_ready_i) r_out_valid <= 1'b0;
      if (r_s1_vld) begin
        if (r_s1_last) begin
          r_acc       <= '0;
          r_sticky    <= 1'b0;
          r_y         <= w_y;
          r_ovf       <= w_ovf;
          r_out_valid <= 1'b1;
        end else begin
          r_acc    <= w_acc_nxt;
          r_sticky <= r_sticky | w_hi | w_lo;
        end
      end
      // Input side closes after a last beat until its result is taken.
      if (w_accept && in_last_i)            r_busy <= 1'b1;
      else if (r_out_valid && out_ready_i)  r_busy <= 1'b0;
    end
  end

  assign in_ready_o  = ~r_busy;
  assign out_valid_o = r_out_valid;
  assign y_out       = r_y;
  assign overflow_o  = r_ovf;
endmodule

// File: tb/tb_fixed_point_mac.sv
module tb_fixed_point_mac;
  localparam int W = 33;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic in_ready0, out_valid0, ovf0, in_ready1, out_valid1, ovf1;
  logic [W-1:0] y0, y1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fixed_point_mac #(.SIGN(1), .Q_M(16), .Q_N(16), .ACC_GUARD(8), .ROUND(0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready0),
    .in_last_i(in_last), .a_in(a), .b_in(b), .out_valid_o(out_valid0),
    .out_ready_i(out_ready), .y_out(y0), .overflow_o(ovf0));

  fixed_point_mac #(.SIGN(1), .Q_M(16), .Q_N(16), .ACC_GUARD(8), .ROUND(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready1),
    .in_last_i(in_last), .a_in(a), .b_in(b), .out_valid_o(out_valid1),
    .out_ready_i(out_ready), .y_out(y1), .overflow_o(ovf1));

  typedef struct {
    string        name;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] y_trunc;
    logic [W-1:0] y_round;
    logic         ovf;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Present a beat at a negedge and step past the accepting posedge.
  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic last);
    int k = 0;
    in_valid = 1'b1; a = av; b = bv; in_last = last;
    while (!in_ready0 && k < 20) begin @(negedge clk); k++; end
    if (k >= 20) chk("send_timeout", 64'(in_ready0), 64'd1);
    @(negedge clk);
  endtask

  // Called right after the last beat was accepted: checks latency, value, handshake.
  task automatic get_result(input string nm, input logic [W-1:0] ey0,
                            input logic [W-1:0] ey1, input logic eovf);
    in_valid = 1'b0; in_last = 1'b0;
    chk({nm, "_lat_early"}, 64'(out_valid0), 64'd0);
    chk({nm, "_rdy_low"},   64'(in_ready0),  64'd0);
    @(negedge clk);
    chk({nm, "_valid"}, 64'(out_valid0), 64'd1);
    chk({nm, "_y"},     64'(y0),         64'(ey0));
    chk({nm, "_ovf"},   64'(ovf0),       64'(eovf));
    chk({nm, "_y_rnd"}, 64'(y1),         64'(ey1));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({nm, "_vld_fall"}, 64'(out_valid0), 64'd0);
    chk({nm, "_rdy_rise"}, 64'(in_ready0),  64'd1);
  endtask

  vec_t tab[8];

  initial begin
    tab[0] = '{"half_sq",   33'h0_00008000, 33'h0_00008000, 33'h0_00004000, 33'h0_00004000, 1'b0};
    tab[1] = '{"round_pos", 33'h0_00000001, 33'h0_00008000, 33'h0_00000000, 33'h0_00000001, 1'b0};
    tab[2] = '{"neg_zero",  33'h1_00000000, 33'h0_00008000, 33'h0_00000000, 33'h0_00000000, 1'b0};
    tab[3] = '{"saturate",  33'h0_FFFF0000, 33'h0_00020000, 33'h0_FFFFFFFF, 33'h0_FFFFFFFF, 1'b1};
    tab[4] = '{"sticky_clr",33'h0_00008000, 33'h0_00008000, 33'h0_00004000, 33'h0_00004000, 1'b0};
    tab[5] = '{"negative",  33'h1_00018000, 33'h0_00020000, 33'h1_00030000, 33'h1_00030000, 1'b0};
    tab[6] = '{"round_neg", 33'h1_00000001, 33'h0_00008000, 33'h0_00000000, 33'h1_00000001, 1'b0};
    tab[7] = '{"max_exact", 33'h0_FFFFFFFF, 33'h0_00010000, 33'h0_FFFFFFFF, 33'h0_FFFFFFFF, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(out_valid0), 64'd0);
    chk("rst_y",     64'(y0),         64'd0);
    chk("rst_ovf",   64'(ovf0),       64'd0);
    chk("rst_ready", 64'(in_ready0),  64'd1);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      send(tab[i].a, tab[i].b, 1'b1);
      get_result(tab[i].name, tab[i].y_trunc, tab[i].y_round, tab[i].ovf);
    end

    // Two-term dot product, back-to-back: 2.25 - 0.25 = 2.0
    send(33'h0_00018000, 33'h0_00018000, 1'b0);
    send(33'h1_00008000, 33'h0_00008000, 1'b1);
    get_result("dot2", 33'h0_00020000, 33'h0_00020000, 1'b0);

    // Bubbles between beats: 1*1 + 1*3 = 4.0
    send(33'h0_00010000, 33'h0_00010000, 1'b0);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    send(33'h0_00010000, 33'h0_00030000, 1'b1);
    get_result("bubble", 33'h0_00040000, 33'h0_00040000, 1'b0);

    // Accumulator clamp: 65535^2 clamps to +max, then -65535*256 brings the
    // sum back into range (0x00FFFFFF) but the sticky flag must still show.
    send(33'h0_FFFF0000, 33'h0_FFFF0000, 1'b0);
    send(33'h1_FFFF0000, 33'h0_01000000, 1'b1);
    get_result("acc_clamp", 33'h0_00FFFFFF, 33'h0_00FFFFFF, 1'b1);

    // Backpressure: hold out_ready low 3 cycles with a stray beat offered.
    send(33'h0_00008000, 33'h0_00008000, 1'b1);
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    chk("bp_valid", 64'(out_valid0), 64'd1);
    in_valid = 1'b1; in_last = 1'b1; a = 33'h0_00100000; b = 33'h0_00100000;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_hold_valid", 64'(out_valid0), 64'd1);
      chk("bp_hold_y",     64'(y0),         64'h0_00004000);
      chk("bp_hold_ready", 64'(in_ready0),  64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    chk("bp_vld_fall", 64'(out_valid0), 64'd0);
    chk("bp_rdy_rise", 64'(in_ready0),  64'd1);
    repeat (3) @(negedge clk);
    chk("bp_no_stray", 64'(out_valid0), 64'd0);

    // Reset mid-vector: partial sums discarded, y_out cleared at once.
    send(33'h0_00640000, 33'h0_00640000, 1'b0);
    send(33'h0_00640000, 33'h0_00640000, 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_y",     64'(y0),         64'd0);
    chk("mid_rst_valid", 64'(out_valid0), 64'd0);
    chk("mid_rst_ready", 64'(in_ready0),  64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(33'h0_00008000, 33'h0_00008000, 1'b1);
    get_result("post_rst", 33'h0_00004000, 33'h0_00004000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fixed_point_mac.md
Name: fixed_point_mac

Overview:
- Streaming sign-magnitude fixed-point multiply-accumulate unit for the perceptron datapath.
- Computes one dot product per vector: sum of a_in*b_in over a burst of beats terminated by in_last_i.
- Uses the same SIGN+Q_M+Q_N word format as the existing fixed-point multiplier. Adds rounding, guarded accumulation, saturation and valid/ready flow control on both sides.
- Sits between the weight/input fetch logic and the activation stage.

Parameters:
- SIGN, 1, sign bit present (1) or unsigned magnitude-only words (0).
- Q_M, 16, integer magnitude bits.
- Q_N, 16, fraction magnitude bits (must be ≥1).
- ACC_GUARD, 8, extra integer guard bits in the internal accumulator.
- ROUND, 0, 0 = truncate product fraction, 1 = round half-up on magnitude.

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- in_valid_i  in  1  operand beat valid.
- in_ready_o  out  1  block can accept a beat.
- in_last_i  in  1  beat is final term of the current vector.
- a_in  in  SIGN+Q_M+Q_N  operand A, sign-magnitude (sign at MSB when SIGN=1).
- b_in  in  SIGN+Q_M+Q_N  operand B, same format.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  downstream accepts result.
- y_out  out  SIGN+Q_M+Q_N  saturated dot-product result, sign-magnitude.
- overflow_o  out  1  result saturated or accumulator clamped during this vector; qualified by out_valid_o.

Behaviour:
- Reset (rst_ni low, asynchronous): out_valid_o=0, y_out=0, overflow_o=0, in_ready_o=1, accumulator=0, sticky overflow=0, pipeline valids=0. Reset mid-vector discards partial sums; no result is produced for that vector.
- Accept: a beat transfers on a rising edge with in_valid_i & in_ready_o.
- Stage 1 (edge of accept): product magnitude = |a|*|b| (2*(Q_M+Q_N) bits), then shifted right by Q_N.
  - ROUND=1: add 2^(Q_N-1) before the shift.
  - Product sign = sa^sb (forced 0 when SIGN=0).
  - Zero magnitude always gives sign 0 (no negative zero).
  - Registered as a two's-complement term with its last flag.
- Stage 2 (next edge): term added to the accumulator, Q_M+Q_N+ACC_GUARD+1 bits two's complement.
  - The first term of a vector adds to zero.
  - Accumulator clamps at its signed range and sets sticky overflow on clamp.
- Output conversion on the last term: acc+term is converted to sign-magnitude.
  - Magnitude saturates to 2^(Q_M+Q_N)-1.
  - SIGN=0 with a negative sum clamps to 0.
  - Either case sets overflow_o.
  - y_out, overflow_o and out_valid_o load on that edge. Accumulator and sticky overflow clear on the same edge.
- Latency: last beat accepted at edge t gives out_valid_o high after edge t+1.
- Single-beat vector: in_last_i on the first beat is legal; result is the single product.
- Flow control:
  - in_ready_o drops after the edge accepting a last beat.
  - It stays low until the edge where out_valid_o & out_ready_i. It rises after that edge, so a new vector may start the following cycle.
  - Non-last beats are accepted back-to-back at one per cycle.
- Output hold: while out_valid_o & ~out_ready_i, y_out and overflow_o are stable. out_valid_o falls after the handshake edge.
- in_valid_i low between beats of a vector is allowed (bubbles); the accumulator holds.
- Operands are sampled only on accept; a_in/b_in are don't-care otherwise.

Test Plan:
- SIGN=1, Q16.16: single beat a=b=0x0_00008000 (0.5), last=1 -> two cycles later out_valid_o=1, y_out=0x0_00004000, overflow_o=0.
- Dot product, beats (1.5,1.5) and (-0.5,0.5) back-to-back, last on beat 2 -> y_out=0x0_00020000 (2.0), sign 0, no overflow.
- Rounding and negative zero:
  - a=0x0_00000001, b=0x0_00008000: ROUND=0 gives y_out=0; ROUND=1 gives y_out=0x0_00000001.
  - a=0x1_00000000, b=0x0_00008000 gives y_out=0x0_00000000 (sign bit 0).
- Saturation: (65535.0, 2.0) single beat -> y_out=0x0_FFFFFFFF, overflow_o=1. Next vector (0.5,0.5) gives overflow_o=0, confirming sticky clear.
- Backpressure: hold out_ready_i low 3 cycles after out_valid_o -> y_out stable, in_ready_o=0, extra in_valid_i beats not accepted. After the handshake edge, out_valid_o=0 and in_ready_o=1.
- Reset mid-vector: accept 2 non-last beats, pulse rst_ni low asynchronously between edges -> outputs reset immediately. Next vector (0.5,0.5,last) gives 0x0_00004000 with no residue.
